// File: rtl/txn_pkg.sv
// rtl/txn_pkg.sv - shared types and constants for the coin transfer engine
package txn_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_S,
    ST_RD_R,
    ST_EVAL,
    ST_WR_S,
    ST_WR_R,
    ST_ANIM_GO,
    ST_ANIM_WAIT,
    ST_DONE
  } txn_state_e;

  typedef enum logic [1:0] {
    TXN_OK       = 2'b00,
    TXN_BAD_KEY  = 2'b01,
    TXN_INSUFF   = 2'b10,
    TXN_OVERFLOW = 2'b11
  } txn_status_e;

  localparam logic ADDR_P0 = 1'b0;
  localparam logic ADDR_P1 = 1'b1;

  function automatic logic player_addr(input logic idx);
    return idx ? ADDR_P1 : ADDR_P0;
  endfunction

endpackage

// File: rtl/txn_balance_alu.sv
// rtl/txn_balance_alu.sv - funds/overflow checks and updated balances for one transfer
module txn_balance_alu #(
  parameter int BAL_W = 8
) (
  input  logic [BAL_W-1:0] bal_s,
  input  logic [BAL_W-1:0] bal_r,
  input  logic [BAL_W-1:0] amount,
  output logic             insufficient,
  output logic             overflow,
  output logic [BAL_W-1:0] new_s,
  output logic [BAL_W-1:0] new_r
);

  logic [BAL_W:0] sum_r;

  // One extra bit so the receiver carry-out is visible as overflow.
  assign sum_r        = {1'b0, bal_r} + {1'b0, amount};
  assign insufficient = ({1'b0, bal_s} < {1'b0, amount});
  assign overflow     = sum_r[BAL_W];
  assign new_s        = bal_s - amount;
  assign new_r        = sum_r[BAL_W-1:0];

endmodule

// File: rtl/transaction_engine.sv
// rtl/transaction_engine.sv - coin transfer slave FSM; TXN_ANIM_EN adds the animation handshake
module transaction_engine
  import txn_pkg::*;
#(
  parameter int BAL_W = 8,
  parameter int KEY_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_transaction,
  input  logic             sender,
  input  logic [BAL_W-1:0] amount,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] expected_key,
  output logic             mem_addr,
  output logic             mem_we,
  output logic [BAL_W-1:0] mem_wdata,
  input  logic [BAL_W-1:0] mem_rdata,
  output logic             anim_start,
  input  logic             anim_done,
  output logic             finished_transaction,
  output logic [1:0]       txn_status
);

  txn_state_e       state;
  logic [BAL_W-1:0] bal_s;
  logic [BAL_W-1:0] bal_r;
  logic             mem_we_q;
  logic [BAL_W-1:0] alu_bal_r;
  logic             insufficient;
  logic             overflow;
  logic [BAL_W-1:0] new_s;
  logic [BAL_W-1:0] new_r;

  // In EVAL the receiver balance is still on the read bus, not yet in bal_r.
  assign alu_bal_r = (state == ST_EVAL) ? mem_rdata : bal_r;

  txn_balance_alu #(.BAL_W(BAL_W)) u_alu (
    .bal_s        (bal_s),
    .bal_r        (alu_bal_r),
    .amount       (amount),
    .insufficient (insufficient),
    .overflow     (overflow),
    .new_s        (new_s),
    .new_r        (new_r)
  );

  // A reset landing on a write cycle must not reach the memory.
  assign mem_we = mem_we_q & resetn;

`ifdef TXN_ANIM_EN
  logic anim_start_q;
  assign anim_start = anim_start_q;
`else
  logic unused_anim_done;
  assign anim_start       = 1'b0;
  assign unused_anim_done = anim_done;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state                <= ST_IDLE;
      bal_s                <= '0;
      bal_r                <= '0;
      mem_addr             <= 1'b0;
      mem_we_q             <= 1'b0;
      mem_wdata            <= '0;
      finished_transaction <= 1'b0;
      txn_status           <= TXN_OK;
`ifdef TXN_ANIM_EN
      anim_start_q         <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
`ifdef TXN_ANIM_EN
      anim_start_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start_transaction) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (key != expected_key) begin
            txn_status           <= TXN_BAD_KEY;
            finished_transaction <= 1'b1;
            state                <= ST_DONE;
          end else begin
            mem_addr <= player_addr(sender);
            state    <= ST_RD_S;
          end
        end
        ST_RD_S: begin
          mem_addr <= player_addr(~sender);
          state    <= ST_RD_R;
        end
        ST_RD_R: begin
          bal_s <= mem_rdata;
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          bal_r <= mem_rdata;
          if (insufficient) begin
            txn_status           <= TXN_INSUFF;
            finished_transaction <= 1'b1;
            state                <= ST_DONE;
          end else if (overflow) begin
            txn_status           <= TXN_OVERFLOW;
            finished_transaction <= 1'b1;
            state                <= ST_DONE;
          end else begin
            txn_status <= TXN_OK;
            mem_we_q   <= 1'b1;
            mem_addr   <= player_addr(sender);
            mem_wdata  <= new_s;
            state      <= ST_WR_S;
          end
        end
        ST_WR_S: begin
          mem_we_q  <= 1'b1;
          mem_addr  <= player_addr(~sender);
          mem_wdata <= new_r;
          state     <= ST_WR_R;
        end
        ST_WR_R: begin
`ifdef TXN_ANIM_EN
          anim_start_q <= 1'b1;
          state        <= ST_ANIM_GO;
`else
          finished_transaction <= 1'b1;
          state                <= ST_DONE;
`endif
        end
`ifdef TXN_ANIM_EN
        ST_ANIM_GO: begin
          state <= ST_ANIM_WAIT;
        end
        ST_ANIM_WAIT: begin
          if (anim_done) begin
            finished_transaction <= 1'b1;
            state                <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (!start_transaction) begin
            finished_transaction <= 1'b0;
            state                <= ST_IDLE;
          end
        end
        default: begin
          finished_transaction <= 1'b0;
          state                <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transaction_engine.sv
// tb/tb_transaction_engine.sv - directed scoreboard bench for transaction_engine
module tb_transaction_engine;

  localparam int BAL_W = 8;
  localparam int KEY_W = 8;
`ifdef TXN_ANIM_EN
  localparam bit ANIM_ON = 1'b1;
`else
  localparam bit ANIM_ON = 1'b0;
`endif
  localparam int ANIM_D = 20;
  localparam int OK_LAT = ANIM_ON ? (8 + ANIM_D) : 6;

  logic             clock = 1'b0;
  logic             resetn;
  logic             start_transaction;
  logic             sender;
  logic [BAL_W-1:0] amount;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] expected_key;
  logic             mem_addr;
  logic             mem_we;
  logic [BAL_W-1:0] mem_wdata;
  logic [BAL_W-1:0] mem_rdata;
  logic             anim_start;
  logic             anim_done;
  logic             finished_transaction;
  logic [1:0]       txn_status;

  logic [BAL_W-1:0] mem [0:1];
  logic             pre_we;
  logic             pre_addr;
  logic [BAL_W-1:0] pre_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic             addr;
    logic [BAL_W-1:0] data;
    int               edge_n;
  } wr_t;
  wr_t sb[$];

  transaction_engine #(.BAL_W(BAL_W), .KEY_W(KEY_W)) dut (
    .clock                (clock),
    .resetn               (resetn),
    .start_transaction    (start_transaction),
    .sender               (sender),
    .amount               (amount),
    .key                  (key),
    .expected_key         (expected_key),
    .mem_addr             (mem_addr),
    .mem_we               (mem_we),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .anim_start           (anim_start),
    .anim_done            (anim_done),
    .finished_transaction (finished_transaction),
    .txn_status           (txn_status)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [BAL_W-1:0] p0, input logic [BAL_W-1:0] p1);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = 1'b0; pre_data = p0;
    @(negedge clock);
    pre_addr = 1'b1; pre_data = p1;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_finished"}, finished_transaction, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 1'b0);
    check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    check({tag, "_anim_start"}, anim_start, 1'b0);
    check({tag, "_status"}, txn_status, 2'b00);
  endtask

  task automatic run_txn(input logic s, input logic [BAL_W-1:0] amt,
                         input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] ek,
                         input logic [1:0] exp_st, input int exp_lat,
                         input logic [BAL_W-1:0] exp_p0, input logic [BAL_W-1:0] exp_p1,
                         input int drop_at);
    wr_t w;
    wr_t got;
    int  kk;
    int  lat;
    int  n_anim;
    int  anim_k;
    bit  exp_anim;
    exp_anim = ANIM_ON && (exp_st == 2'b00);
    if (exp_st == 2'b00) begin
      w.addr = s;  w.data = s ? exp_p1 : exp_p0; w.edge_n = 5; sb.push_back(w);
      w.addr = ~s; w.data = s ? exp_p0 : exp_p1; w.edge_n = 6; sb.push_back(w);
    end
    @(negedge clock);
    sender = s; amount = amt; key = k; expected_key = ek;
    start_transaction = 1'b1; anim_done = 1'b0;
    @(posedge clock);
    kk = -1; lat = -1; n_anim = 0; anim_k = -1;
    while (lat < 0 && kk < 80) begin
      @(negedge clock);
      kk++;
      if (kk == drop_at) start_transaction = 1'b0;
      if (mem_we) begin
        check("write_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("write_addr", mem_addr, got.addr);
          check("write_data", mem_wdata, got.data);
          check("write_edge", kk + 1, got.edge_n);
        end
      end
      if (anim_start) begin
        n_anim++;
        anim_k = kk;
      end
      if (ANIM_ON && kk == 7 + ANIM_D) anim_done = 1'b1;
      if (finished_transaction) lat = kk;
    end
    anim_done = 1'b0;
    check("finish_latency", lat, exp_lat);
    check("status", txn_status, exp_st);
    check("writes_drained", sb.size(), 0);
    sb.delete();
    check("bal_p0", mem[0], exp_p0);
    check("bal_p1", mem[1], exp_p1);
    check("anim_pulses", n_anim, exp_anim ? 1 : 0);
    if (exp_anim) check("anim_edge", anim_k, 6);
    if (drop_at < 0) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        check("finished_held", finished_transaction, 1'b1);
      end
      start_transaction = 1'b0;
    end
    @(negedge clock);
    check("finished_dropped", finished_transaction, 1'b0);
    check("status_held", txn_status, exp_st);
  endtask

  initial begin
    resetn = 1'b0; start_transaction = 1'b0; sender = 1'b0; amount = '0;
    key = '0; expected_key = '0; anim_done = 1'b0;
    pre_we = 1'b0; pre_addr = 1'b0; pre_data = '0;
    repeat (2) @(negedge clock);
    check_idle_outputs("reset");
    resetn = 1'b1;

    preload(8'd100, 8'd20);
    run_txn(1'b0, 8'd30, 8'h3C, 8'h3C, 2'b00, OK_LAT, 8'd70, 8'd50, -1);
    run_txn(1'b0, 8'd30, 8'h5A, 8'h3C, 2'b01, 1, 8'd70, 8'd50, -1);

    preload(8'd5, 8'd10);
    run_txn(1'b1, 8'd11, 8'h3C, 8'h3C, 2'b10, 4, 8'd5, 8'd10, -1);
    run_txn(1'b1, 8'd10, 8'h3C, 8'h3C, 2'b00, OK_LAT, 8'd15, 8'd0, 2);

    preload(8'd250, 8'd100);
    run_txn(1'b1, 8'd6, 8'hA1, 8'hA1, 2'b11, 4, 8'd250, 8'd100, -1);
    preload(8'd249, 8'd100);
    run_txn(1'b1, 8'd6, 8'hA1, 8'hA1, 2'b00, OK_LAT, 8'd255, 8'd94, -1);

    preload(8'd40, 8'd60);
    run_txn(1'b0, 8'd0, 8'h07, 8'h07, 2'b00, OK_LAT, 8'd40, 8'd60, 1);

    // Reset while the sender write is on the bus.
    preload(8'd100, 8'd20);
    @(negedge clock);
    sender = 1'b0; amount = 8'd30; key = 8'h3C; expected_key = 8'h3C;
    start_transaction = 1'b1;
    @(posedge clock);
    repeat (5) @(negedge clock);
    check("wr_s_mem_we", mem_we, 1'b1);
    check("wr_s_wdata", mem_wdata, 8'd70);
    resetn = 1'b0;
    start_transaction = 1'b0;
    #1;
    check("reset_gates_we", mem_we, 1'b0);
    @(negedge clock);
    check_idle_outputs("mid_reset");
    check("mid_reset_p0", mem[0], 8'd100);
    check("mid_reset_p1", mem[1], 8'd20);
    resetn = 1'b1;
    run_txn(1'b0, 8'd30, 8'h3C, 8'h3C, 2'b00, OK_LAT, 8'd70, 8'd50, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
